spi_target: RTL

- SPI target (slave) endpoint: the far end of the SPI controller already in the design.
- Receives MOSI bytes and returns MISO bytes in any of the four CPOL/CPHA modes, MSB first.
- Oversamples sclk, ss_n and mosi into the system clock domain, so no logic runs on sclk.
- Sits between the board SPI pins and a byte-wide valid/ready interface to local logic.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_target.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions, used by this target and by the SPI controller.
// Contents: the FSM state encoding, the SPI mode constants ({cpol,cpha})
// and the default underrun fill word.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic [7:0] IDLE_TX_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with edge pulses.
// Ports:
//   clock, reset  - system clock, synchronous active-low reset
//   preset        - value the chain is filled with during reset
//   d             - asynchronous input
//   level         - synchronized level
//   rise, fall    - one-cycle pulses on a synchronized level change
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic preset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   level_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      chain   <= {SYNC_STAGES{preset}};
      level_d <= preset;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], d};
      level_d <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint. sclk, ss_n and mosi are oversampled in the clock
// domain; words are exchanged with local logic over a byte valid/ready
// interface (one-entry tx holding register, rx pulse without back-pressure).
// Ports:
//   clock, reset              - system clock (>= 8x sclk), sync active-low reset
//   cpol, cpha                - SPI mode, captured while idle
//   sclk, ss_n, mosi          - asynchronous SPI pins
//   miso, miso_oe             - serial out and pad enable
//   tx_data/tx_valid/tx_ready - word to send next
//   rx_data/rx_valid          - last received word and its one-cycle strobe
//   busy                      - frame active
//   tx_underrun               - IDLE_TX was loaded instead of user data
//
// state  | meaning
// IDLE   | select inactive, miso tristated, mode inputs tracked
// ACTIVE | frame in progress, shifting on synchronized sclk edges
module spi_target
  import spi_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  IDLE_TX     = WIDTH'(IDLE_TX_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  spi_state_e state, state_nxt;

  logic                   cpol_q, cpha_q;
  logic                   sclk_s, sclk_rise, sclk_fall;
  logic                   ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-2:0] rx_shift;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             miso_q;

  logic lead_edge, trail_edge, in_frame, sample_edge, shift_edge;
  logic start, frame_end, word_done, load, wr;
  logic [WIDTH-1:0] load_word;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .preset(cpol),
    .d     (sclk),
    .level (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clock (clock),
    .reset (reset),
    .preset(1'b1),
    .d     (ss_n),
    .level (ss_s),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  always_ff @(posedge clock) begin
    if (!reset) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // sclk_s itself is only needed through its edge pulses
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  // sclk edges seen after select has gone away belong to no word
  assign in_frame    = (state == ACTIVE) && !ss_s;
  assign sample_edge = in_frame && (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = in_frame && (cpha_q ? lead_edge : trail_edge);

  assign start     = (state == IDLE) && ss_fall;
  assign frame_end = (state == ACTIVE) && ss_rise;
  assign word_done = sample_edge && (bit_cnt == LAST_BIT);
  assign load      = start || word_done;
  assign wr        = tx_valid && !hold_full;
  assign load_word = hold_full ? hold_data : IDLE_TX;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    miso_oe = 1'b0;
    if (state == ACTIVE) begin
      busy    = 1'b1;
      miso_oe = 1'b1;
    end
  end

  // ---------------- datapath ----------------
  // miso is always a register. At frame entry it gets the first MSB; in
  // cpha=0 tx_shift is pre-shifted so every later shift edge, including the
  // one after a word boundary reload, just presents tx_shift's MSB.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpol_q      <= cpol;
      cpha_q      <= cpha;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (state == IDLE) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end

      if (load) begin
        tx_shift <= (start && !cpha_q) ? {load_word[WIDTH-2:0], 1'b0} : load_word;
        if (start) miso_q <= load_word[WIDTH-1];
        if (hold_full) hold_full   <= 1'b0;
        else           tx_underrun <= 1'b1;
      end else if (shift_edge) begin
        miso_q   <= tx_shift[WIDTH-1];
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end

      // wr implies the holding register is empty, so it never races a drain
      if (wr) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (start || frame_end) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[WIDTH-3:0], mosi_s};
        if (word_done) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  assign miso     = miso_q;
  assign tx_ready = ~hold_full;

endmodule
